// File: rtl/logs_sum_pipe.sv
// logs_sum_pipe: registered binary adder tree, one tree level per clock stage, valid/ready with full-pipeline stall.
// Define LOGS_SUM_PIPE_SAT_EN to make every adder saturate at 2^NBITS-1 instead of wrapping.
module logs_sum_pipe #(
    parameter int NBITS    = 3,
    parameter int NADDENDS = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NADDENDS*NBITS-1:0] in_addends,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NBITS-1:0]          out_sum,
    output logic                      out_valid,
    input  logic                      out_ready
);
    localparam int LEVELS = (NADDENDS == 1) ? 1 : $clog2(NADDENDS);

    logic              advance;
    logic [LEVELS-1:0] v_d;
    logic [LEVELS-1:0] v_q;

    function automatic logic [NBITS-1:0] add_pair(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
`ifdef LOGS_SUM_PIPE_SAT_EN
        logic [NBITS:0] wide;
        wide = {1'b0, a} + {1'b0, b};
        return wide[NBITS] ? {NBITS{1'b1}} : wide[NBITS-1:0];
`else
        return a + b;
`endif
    endfunction

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[LEVELS-1];

    // Bit i of the valid chain belongs to stage i+1; the whole chain shifts only on advance.
    always_comb begin
        v_d = v_q;
        if (advance) begin
            v_d = LEVELS'({v_q, in_valid});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int PREV_CNT = (NADDENDS + (1 << (k - 1)) - 1) >> (k - 1);
        localparam int CNT      = (NADDENDS + (1 << k) - 1) >> k;

        logic [PREV_CNT*NBITS-1:0] src;
        logic [CNT*NBITS-1:0]      part_d;
        logic [CNT*NBITS-1:0]      part_q;

        if (k == 1) begin : g_src_in
            assign src = in_addends;
        end else begin : g_src_prev
            assign src = g_lvl[k-1].part_q;
        end

        // An unpaired last partial is added to zero, which passes it through in both arithmetic modes.
        always_comb begin
            int idx_b;
            idx_b  = 0;
            part_d = part_q;
            if (advance) begin
                for (int j = 0; j < CNT; j++) begin
                    idx_b = (2 * j + 1 < PREV_CNT) ? 2 * j + 1 : 2 * j;
                    part_d[j*NBITS +: NBITS] = add_pair(src[2*j*NBITS +: NBITS],
                        (2 * j + 1 < PREV_CNT) ? src[idx_b*NBITS +: NBITS] : {NBITS{1'b0}});
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                part_q <= '0;
            end else begin
                part_q <= part_d;
            end
        end
    end

    assign out_sum = g_lvl[LEVELS].part_q;

endmodule
